pulso_led: RTL

Output-side counterpart to the push-button pulse generator. It converts one-cycle event pulses from the Breakout game logic (hit, life lost, level clear) into visible fixed-length blinks on an active-low LED pin. Events that arrive while a blink is in progress are queued and replayed as separate blinks, with a dark gap between each.

---
 rtl/pulso_led.sv | 139 +++++++++++++
 1 files changed

// File: rtl/pulso_led.sv
// rtl/pulso_led.sv - turns one-cycle event pulses into fixed-length blinks on an active-low LED
// Define PULSO_LED_FILA_EN to build the pending-event queue; otherwise busy-time events are dropped.
module pulso_led #(
    parameter int ON_CYCLES   = 4,
    parameter int OFF_CYCLES  = 2,
    parameter int QUEUE_DEPTH = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic evento,
    output logic led_n,
    output logic ocupado,
    output logic perdido
);

    localparam int CNT_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    // The counter only ever holds load values, so CNT_MAX-1 is the largest value needed.
    localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] OFF_LOAD = CW'(OFF_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            led_n_q, led_n_d;
    logic            ocupado_q, ocupado_d;
    logic            perdido_q, perdido_d;

`ifdef PULSO_LED_FILA_EN
    localparam int PW = $clog2(QUEUE_DEPTH + 1);
    logic [PW-1:0]   pend_q, pend_d;
    logic            deq;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        led_n_d   = led_n_q;
        perdido_d = 1'b0;
`ifdef PULSO_LED_FILA_EN
        pend_d    = pend_q;
        deq       = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                led_n_d = 1'b1;
                if (evento) begin
                    state_d = S_ON;
                    cnt_d   = ON_LOAD;
                    led_n_d = 1'b0;
                end
            end
            S_ON: begin
                led_n_d = 1'b0;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = S_GAP;
                    cnt_d   = OFF_LOAD;
                    led_n_d = 1'b1;
                end
            end
            S_GAP: begin
                led_n_d = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end
`ifdef PULSO_LED_FILA_EN
                else if (pend_q != '0) begin
                    state_d = S_ON;
                    cnt_d   = ON_LOAD;
                    led_n_d = 1'b0;
                    deq     = 1'b1;
                end
`endif
                else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE && evento) begin
`ifdef PULSO_LED_FILA_EN
            // An event arriving on a dequeue cycle takes the freed slot, so it never drops.
            if (!deq) begin
                if (pend_q < PW'(QUEUE_DEPTH)) begin
                    pend_d = pend_q + PW'(1);
                end else begin
                    perdido_d = 1'b1;
                end
            end
`else
            perdido_d = 1'b1;
`endif
        end

`ifdef PULSO_LED_FILA_EN
        if (deq && !evento) begin
            pend_d = pend_q - PW'(1);
        end
        ocupado_d = (state_d != S_IDLE) || (pend_d != '0);
`else
        ocupado_d = (state_d != S_IDLE);
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            led_n_q   <= 1'b1;
            ocupado_q <= 1'b0;
            perdido_q <= 1'b0;
`ifdef PULSO_LED_FILA_EN
            pend_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            led_n_q   <= led_n_d;
            ocupado_q <= ocupado_d;
            perdido_q <= perdido_d;
`ifdef PULSO_LED_FILA_EN
            pend_q    <= pend_d;
`endif
        end
    end

    assign led_n   = led_n_q;
    assign ocupado = ocupado_q;
    assign perdido = perdido_q;

endmodule
